// File: rtl/sprite_rom_arbiter.sv
// Sprite/tile ROM arbiter: client 0 has strict priority, the rest are served
// round-robin, and read data returns to its owner after a fixed latency.
module sprite_rom_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      rom_rd,
    input  logic [DATA_W-1:0]         rom_q,
    output logic                      busy
);

    localparam int PW    = $clog2(NUM_REQ);
    localparam int DEPTH = ROM_LAT + 1;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    logic [NUM_REQ-1:0] win;
    logic [ADDR_W-1:0]  win_addr;
    logic               grant;
    logic               tag_busy;
    logic [NUM_REQ-1:0] tag_q [DEPTH];

    // Priority client first, then a circular search over 1..NUM_REQ-1.
    always_comb begin : arb
        int idx;
        idx      = 0;
        win      = '0;
        rr_next  = rr_ptr;
        win_addr = '0;
        if (req[0]) begin
            win[0] = 1'b1;
        end else begin
            for (int off = 0; off < NUM_REQ - 1; off++) begin
                idx = int'(rr_ptr) + off;
                if (idx >= NUM_REQ)
                    idx = idx - (NUM_REQ - 1);
                if (win == '0 && req[idx]) begin
                    win[idx] = 1'b1;
                    rr_next  = (idx + 1 == NUM_REQ) ? PW'(1) : PW'(idx + 1);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i])
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign gnt   = Reset ? '0 : win;
    assign grant = |gnt;

    // Stages that will still hold a tag after this edge; stage 0 reloads from gnt.
    always_comb begin
        tag_busy = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++)
            tag_busy = tag_busy | (|tag_q[k]);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr   <= PW'(1);
            rom_addr <= '0;
            rom_rd   <= 1'b0;
            rvalid   <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            for (int k = 0; k < DEPTH; k++)
                tag_q[k] <= '0;
        end else begin
            rom_rd <= grant;
            if (grant) begin
                rom_addr <= win_addr;
                rr_ptr   <= rr_next;
            end
            tag_q[0] <= gnt;
            for (int k = 1; k < DEPTH; k++)
                tag_q[k] <= tag_q[k-1];
            rvalid <= tag_q[DEPTH-1];
            if (|tag_q[DEPTH-1])
                rdata <= rom_q;
            busy <= grant | tag_busy;
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: per-cycle vector table plus
// hand-written streaming and reset-mid-flight sequences.
module tb_sprite_rom_arbiter;

    localparam int L = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [2:0]  req;
    logic [47:0] req_addr;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic [15:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_q;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    sprite_rom_arbiter #(
        .NUM_REQ(3), .ADDR_W(16), .DATA_W(8), .ROM_LAT(L)
    ) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_addr(req_addr),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr),
        .rom_rd(rom_rd), .rom_q(rom_q), .busy(busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        return a[7:0] ^ 8'h86;
    endfunction

    // ROM model: address sampled at the edge, data appears L cycles later.
    logic [7:0] q_pipe [L];
    always @(posedge Clk) begin
        q_pipe[0] <= rom_fn(rom_addr);
        for (int k = 1; k < L; k++)
            q_pipe[k] <= q_pipe[k-1];
    end
    assign rom_q = q_pipe[L-1];

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [15:0] a0, a1, a2;
        logic [2:0]  gnt;
        logic        rd;
        logic [15:0] ra;
        logic [2:0]  rv;
        logic [7:0]  rdat;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst, input logic [2:0] rq,
        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
        input logic [2:0] g, input logic rd, input logic [15:0] ra,
        input logic [2:0] rv, input logic [7:0] rdat, input logic bsy);
        vec_t v;
        v.rst = rst; v.req = rq; v.a0 = a0; v.a1 = a1; v.a2 = a2;
        v.gnt = g; v.rd = rd; v.ra = ra; v.rv = rv; v.rdat = rdat;
        v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        repeat (2) @(posedge Clk);
        #1;

        // Reset with all requests high, then idle
        tbl.push_back(mk(1, 3'b111, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0));
        // Single read by client 1
        tbl.push_back(mk(0, 3'b010, 0, 16'h0123, 0, 3'b010, 0, 0, 0, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0123, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0123, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0123, 0, 8'h00, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0123, 3'b010, 8'hA5, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0123, 0, 8'hA5, 0));
        // Priority: all three request, client 0 always wins
        tbl.push_back(mk(0, 3'b111, 16'h10, 16'h20, 16'h30, 3'b001, 0, 16'h0123, 0, 8'hA5, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 3'b111, 16'h10, 16'h20, 16'h30, 3'b001, 1, 16'h0010, 0, 8'hA5, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0010, 3'b001, 8'h96, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0010, 3'b001, 8'h96, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0010, 3'b001, 8'h96, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0010, 3'b001, 8'h96, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0010, 0, 8'h96, 0));
        // Round-robin; rr_ptr is 2 after the earlier client-1 grant
        tbl.push_back(mk(0, 3'b110, 0, 16'h41, 16'h52, 3'b100, 0, 16'h0010, 0, 8'h96, 0));
        tbl.push_back(mk(0, 3'b110, 0, 16'h41, 16'h52, 3'b010, 1, 16'h0052, 0, 8'h96, 1));
        tbl.push_back(mk(0, 3'b110, 0, 16'h41, 16'h52, 3'b100, 1, 16'h0041, 0, 8'h96, 1));
        tbl.push_back(mk(0, 3'b110, 0, 16'h41, 16'h52, 3'b010, 1, 16'h0052, 0, 8'h96, 1));
        tbl.push_back(mk(0, 3'b110, 0, 16'h41, 16'h52, 3'b100, 1, 16'h0041, 3'b100, 8'hD4, 1));
        tbl.push_back(mk(0, 3'b110, 0, 16'h41, 16'h52, 3'b010, 1, 16'h0052, 3'b010, 8'hC7, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0041, 3'b100, 8'hD4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0041, 3'b010, 8'hC7, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0041, 3'b100, 8'hD4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0041, 3'b010, 8'hC7, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0041, 0, 8'hC7, 0));

        foreach (tbl[i]) begin
            Reset    = tbl[i].rst;
            req      = tbl[i].req;
            req_addr = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
            @(negedge Clk);
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("row%0d rom_rd", i), 32'(rom_rd), 32'(tbl[i].rd));
            chk($sformatf("row%0d rom_addr", i), 32'(rom_addr), 32'(tbl[i].ra));
            chk($sformatf("row%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            chk($sformatf("row%0d rdata", i), 32'(rdata), 32'(tbl[i].rdat));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            next_cycle();
        end

        // Streaming: client 0 reads 0..7 back to back
        for (int c = 0; c < 13; c++) begin
            req      = (c < 8) ? 3'b001 : 3'b000;
            req_addr = {32'h0, 16'(c)};
            @(negedge Clk);
            if (c < 8)
                chk($sformatf("stream gnt c%0d", c), 32'(gnt), 32'h1);
            if (c >= 4 && c < 12) begin
                chk($sformatf("stream rvalid c%0d", c), 32'(rvalid), 32'h1);
                chk($sformatf("stream rdata c%0d", c), 32'(rdata),
                    32'(rom_fn(16'(c - 4))));
            end
            if (c >= 1 && c <= 10)
                chk($sformatf("stream busy c%0d", c), 32'(busy), 32'h1);
            if (c == 11)
                chk("stream busy end", 32'(busy), 32'h0);
            if (c == 12)
                chk("stream rvalid end", 32'(rvalid), 32'h0);
            next_cycle();
        end

        // Reset mid-flight: two grants, then a one-cycle reset
        req      = 3'b110;
        req_addr = {16'h0202, 16'h0101, 16'h0000};
        @(negedge Clk);
        chk("rst seq gnt0", 32'(gnt), 32'h4);
        next_cycle();
        @(negedge Clk);
        chk("rst seq gnt1", 32'(gnt), 32'h2);
        next_cycle();
        req   = 3'b000;
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst seq gnt forced", 32'(gnt), 32'h0);
        next_cycle();
        Reset = 1'b0;
        @(negedge Clk);
        chk("post rst rom_rd", 32'(rom_rd), 32'h0);
        chk("post rst rom_addr", 32'(rom_addr), 32'h0);
        chk("post rst rdata", 32'(rdata), 32'h0);
        chk("post rst busy", 32'(busy), 32'h0);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("post rst rvalid c%0d", c), 32'(rvalid), 32'h0);
            next_cycle();
            @(negedge Clk);
        end
        next_cycle();
        req = 3'b110;
        @(negedge Clk);
        chk("post rst rr_ptr", 32'(gnt), 32'h2);
        next_cycle();
        req = 3'b000;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
